// File: rtl/vliw_bundle_queue.sv
// Decode-stage bundle queue for the 4-lane VLIW core: FIFO + Decode register with NOP expansion.
// Latency: 1 cycle bypass when empty and unstalled, otherwise head loads on the first advancing edge.
// Backpressure: BundleReadyF drops only when the FIFO is full or in reset; StallD never blocks pushes.

package vliw_cfg_pkg;
    typedef struct packed {
        int unsigned XLEN;
    } cvw_t;

    localparam cvw_t VLIW_DEFAULT_CFG = '{XLEN: 32};
endpackage

// Generic circular FIFO with separate count and synchronous clear.
// Latency: head entry visible combinationally the cycle after its push.
// Backpressure: none internal; the caller must never push when full or pop when empty.
module vliw_bq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push_vld,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop_rdy,
    output logic [WIDTH-1:0] o_head_dat,
    output logic [CW-1:0]    o_count
);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Data array is deliberately unreset; it is only read while count > 0.
    always_ff @(posedge clk) begin
        if (i_push_vld) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push_vld) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (i_pop_rdy) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({i_push_vld, i_pop_rdy})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;
endmodule

module vliw_bundle_queue
    import vliw_cfg_pkg::*;
#(
    parameter cvw_t P     = VLIW_DEFAULT_CFG,
    parameter int   DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [127:0]                 BundleF,
    input  logic [3:0]                   SlotMaskF,
    input  logic [P.XLEN-1:0]            BundlePCF,
    input  logic                         BundleValidF,
    output logic                         BundleReadyF,
    input  logic                         StallD,
    input  logic                         FlushD,
    output logic [31:0]                  InstrD_0,
    output logic [31:0]                  InstrD_1,
    output logic [31:0]                  InstrD_2,
    output logic [31:0]                  InstrD_3,
    output logic                         InstrValidD_0,
    output logic                         InstrValidD_1,
    output logic                         InstrValidD_2,
    output logic                         InstrValidD_3,
    output logic [P.XLEN-1:0]            PCD,
    output logic [$clog2(DEPTH+1)-1:0]   Occupancy
);
    localparam int XLEN = P.XLEN;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [3:0]      mask;
        logic [127:0]    bundle;
    } bq_entry_t;

    bq_entry_t        w_push_entry;
    bq_entry_t        w_head;
    bq_entry_t        w_src;
    logic [CW-1:0]    w_count;
    logic             w_push;
    logic             w_adv;
    logic             w_pop;
    logic             w_bypass;
    logic             w_fifo_push;

    logic [3:0][31:0] r_instr;
    logic [3:0]       r_vld;
    logic [XLEN-1:0]  r_pc;

    assign w_push_entry = '{pc: BundlePCF, mask: SlotMaskF, bundle: BundleF};

    assign BundleReadyF = (w_count < DEPTH_C) & reset;
    assign w_push       = BundleValidF & BundleReadyF & ~FlushD;
    assign w_adv        = ~StallD & ~FlushD;
    assign w_pop        = w_adv & (w_count != '0);
    // An empty queue hands the incoming bundle straight to Decode without touching the FIFO.
    assign w_bypass     = w_adv & (w_count == '0) & w_push;
    assign w_fifo_push  = w_push & ~w_bypass;
    assign w_src        = w_pop ? w_head : w_push_entry;

    vliw_bq_fifo #(
        .WIDTH ($bits(bq_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .i_flush    (FlushD),
        .i_push_vld (w_fifo_push),
        .i_push_dat (w_push_entry),
        .i_pop_rdy  (w_pop),
        .o_head_dat (w_head),
        .o_count    (w_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_instr <= {4{NOP}};
            r_vld   <= '0;
            r_pc    <= '0;
        end else if (FlushD || (w_adv && !(w_pop || w_bypass))) begin
            // Bubble keeps the last PC so lane PCs stay meaningful for debug.
            r_instr <= {4{NOP}};
            r_vld   <= '0;
        end else if (w_pop || w_bypass) begin
            for (int i = 0; i < 4; i++) begin
                r_instr[i] <= w_src.mask[i] ? w_src.bundle[32*i +: 32] : NOP;
            end
            r_vld <= w_src.mask;
            r_pc  <= w_src.pc;
        end
    end

    assign InstrD_0      = r_instr[0];
    assign InstrD_1      = r_instr[1];
    assign InstrD_2      = r_instr[2];
    assign InstrD_3      = r_instr[3];
    assign InstrValidD_0 = r_vld[0];
    assign InstrValidD_1 = r_vld[1];
    assign InstrValidD_2 = r_vld[2];
    assign InstrValidD_3 = r_vld[3];
    assign PCD           = r_pc;
    assign Occupancy     = w_count;
endmodule

// File: tb/tb_vliw_bundle_queue.sv
// Scoreboard bench for vliw_bundle_queue: directed pushes queue expected Decode bundles,
// a negedge monitor compares every newly loaded valid Decode bundle in order.
module tb_vliw_bundle_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [3:0][31:0] instr;
        logic [3:0]       vld;
        logic [31:0]      pc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] BundleF;
    logic [3:0]   SlotMaskF;
    logic [31:0]  BundlePCF;
    logic         BundleValidF;
    logic         BundleReadyF;
    logic         StallD;
    logic         FlushD;
    logic [31:0]  InstrD_0, InstrD_1, InstrD_2, InstrD_3;
    logic         InstrValidD_0, InstrValidD_1, InstrValidD_2, InstrValidD_3;
    logic [31:0]  PCD;
    logic [2:0]   Occupancy;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    logic adv_q = 1'b0;

    vliw_bundle_queue #(.DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .BundleF       (BundleF),
        .SlotMaskF     (SlotMaskF),
        .BundlePCF     (BundlePCF),
        .BundleValidF  (BundleValidF),
        .BundleReadyF  (BundleReadyF),
        .StallD        (StallD),
        .FlushD        (FlushD),
        .InstrD_0      (InstrD_0),
        .InstrD_1      (InstrD_1),
        .InstrD_2      (InstrD_2),
        .InstrD_3      (InstrD_3),
        .InstrValidD_0 (InstrValidD_0),
        .InstrValidD_1 (InstrValidD_1),
        .InstrValidD_2 (InstrValidD_2),
        .InstrValidD_3 (InstrValidD_3),
        .PCD           (PCD),
        .Occupancy     (Occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [127:0] b, input logic [3:0] m, input logic [31:0] pc);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.instr[i] = m[i] ? b[32*i +: 32] : NOP;
        end
        e.vld = m;
        e.pc  = pc;
        return e;
    endfunction

    function automatic logic [127:0] mkb(input logic [31:0] pc);
        return {pc + 32'hC0, pc + 32'h80, pc + 32'h40, pc | 32'h1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [127:0] b, input logic [3:0] m, input logic [31:0] pc, input bit exp_issue);
        BundleF      = b;
        SlotMaskF    = m;
        BundlePCF    = pc;
        BundleValidF = 1'b1;
        if (exp_issue) sb.push_back(model(b, m, pc));
        step();
        BundleValidF = 1'b0;
    endtask

    task automatic check_bubble_state(input string tag, input logic ready_req);
        check({tag, "_instr0"}, InstrD_0, NOP);
        check({tag, "_instr1"}, InstrD_1, NOP);
        check({tag, "_instr2"}, InstrD_2, NOP);
        check({tag, "_instr3"}, InstrD_3, NOP);
        check({tag, "_valids"}, {InstrValidD_3, InstrValidD_2, InstrValidD_1, InstrValidD_0}, 4'b0000);
        check({tag, "_pcd"}, PCD, 32'h0);
        check({tag, "_occ"}, Occupancy, 3'd0);
        check({tag, "_ready"}, BundleReadyF, ready_req);
    endtask

    // Decode loads a new bundle only on edges where reset is high and neither stall nor flush is set.
    always @(posedge clk) adv_q <= reset & ~StallD & ~FlushD;

    always @(negedge clk) begin
        if (adv_q && (InstrValidD_0 | InstrValidD_1 | InstrValidD_2 | InstrValidD_3)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_bundle: actual PCD=%0h required no valid bundle", PCD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mon_instr0", InstrD_0, e.instr[0]);
                check("mon_instr1", InstrD_1, e.instr[1]);
                check("mon_instr2", InstrD_2, e.instr[2]);
                check("mon_instr3", InstrD_3, e.instr[3]);
                check("mon_valids", {InstrValidD_3, InstrValidD_2, InstrValidD_1, InstrValidD_0}, e.vld);
                check("mon_pcd", PCD, e.pc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset        = 1'b0;
        BundleF      = '0;
        SlotMaskF    = '0;
        BundlePCF    = '0;
        BundleValidF = 1'b0;
        StallD       = 1'b0;
        FlushD       = 1'b0;

        // Reset
        step();
        step();
        check_bubble_state("reset", 1'b0);
        reset = 1'b1;
        #1;
        check("ready_after_reset", BundleReadyF, 1'b1);

        // Bypass latency
        offer({32'h0000_0000, 32'h0020_8193, 32'h00A0_0113, 32'h0050_0093}, 4'b0111, 32'h8000_0000, 1'b1);
        check("bypass_occ", Occupancy, 3'd0);
        check("bypass_instr0", InstrD_0, 32'h0050_0093);
        check("bypass_instr3", InstrD_3, NOP);
        check("bypass_pcd", PCD, 32'h8000_0000);
        step();

        // Fill / full
        StallD = 1'b1;
        for (int k = 0; k < 4; k++) begin
            offer(mkb(32'h100 + 32'(16 * k)), 4'hF, 32'h100 + 32'(16 * k), 1'b1);
        end
        check("full_occ", Occupancy, 3'd4);
        check("full_ready", BundleReadyF, 1'b0);
        offer(mkb(32'h140), 4'hF, 32'h140, 1'b0);
        check("full_5th_rejected_occ", Occupancy, 3'd4);
        StallD = 1'b0;
        step();
        check("ready_after_first_pop", BundleReadyF, 1'b1);
        check("drain_occ3", Occupancy, 3'd3);
        for (int k = 2; k >= 0; k--) begin
            step();
            check("drain_occ", Occupancy, 3'(k));
        end
        step();

        // Wrap and concurrency
        StallD = 1'b1;
        offer(mkb(32'h200), 4'hF, 32'h200, 1'b1);
        offer(mkb(32'h210), 4'b1001, 32'h210, 1'b1);
        check("wrap_prefill_occ", Occupancy, 3'd2);
        StallD = 1'b0;
        for (int k = 0; k < 10; k++) begin
            offer(mkb(32'h220 + 32'(16 * k)), (k % 2 == 1) ? 4'b1010 : 4'b0101, 32'h220 + 32'(16 * k), 1'b1);
            check("wrap_occ", Occupancy, 3'd2);
        end
        step();
        step();
        check("wrap_drained_occ", Occupancy, 3'd0);
        step();

        // Flush
        offer(mkb(32'h300), 4'hF, 32'h300, 1'b1);
        StallD = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            offer(mkb(32'h300 + 32'(16 * k)), 4'hF, 32'h300 + 32'(16 * k), 1'b0);
        end
        check("flush_pre_occ", Occupancy, 3'd3);
        FlushD = 1'b1;
        offer(mkb(32'h340), 4'hF, 32'h340, 1'b0);
        FlushD = 1'b0;
        check("flush_occ", Occupancy, 3'd0);
        check("flush_valids", {InstrValidD_3, InstrValidD_2, InstrValidD_1, InstrValidD_0}, 4'b0000);
        StallD = 1'b0;
        offer(mkb(32'h350), 4'b0011, 32'h350, 1'b1);
        check("post_flush_bypass_occ", Occupancy, 3'd0);
        step();

        // Reset mid-operation
        offer(mkb(32'h400), 4'hF, 32'h400, 1'b1);
        StallD = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            offer(mkb(32'h400 + 32'(16 * k)), 4'hF, 32'h400 + 32'(16 * k), 1'b0);
        end
        check("midreset_pre_occ", Occupancy, 3'd3);
        StallD = 1'b0;
        reset  = 1'b0;
        step();
        check_bubble_state("midreset", 1'b0);
        reset = 1'b1;
        repeat (3) step();
        check("midreset_no_stale_valids", {InstrValidD_3, InstrValidD_2, InstrValidD_1, InstrValidD_0}, 4'b0000);
        check("midreset_no_stale_occ", Occupancy, 3'd0);
        offer(mkb(32'h450), 4'hF, 32'h450, 1'b1);
        repeat (3) step();

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vliw_bundle_queue.md
# vliw_bundle_queue

Decode-stage bundle buffer for the 4-lane VLIW integer core. It accepts 128-bit instruction bundles from the fetch unit through a valid/ready handshake and holds them in a small FIFO. Each bundle is split into four 32-bit slots that drive the per-lane integer execution units' `InstrD`. Empty slots are replaced with canonical NOPs, and the block handles Decode-stage stall and flush.

## Interface
Parameters:
- `P`, cvw_t config. Uses `P.XLEN` for PC width.
- `DEPTH`, default 4. FIFO entries, power of 2, at least 2.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `BundleF`  in  128  fetched bundle. Slot *i* is bits [32i+31:32i].
- `SlotMaskF`  in  4  bit *i* = slot *i* holds a real instruction.
- `BundlePCF`  in  XLEN  PC of slot 0.
- `BundleValidF`  in  1  fetch offers a bundle.
- `BundleReadyF`  out  1  queue can accept a bundle this cycle.
- `StallD`  in  1  hold the Decode register.
- `FlushD`  in  1  discard the Decode bundle and all queued bundles.
- `InstrD_0`..`InstrD_3`  out  32 each  per-lane Decode instruction.
- `InstrValidD_0`..`InstrValidD_3`  out  1 each  per-lane slot valid.
- `PCD`  out  XLEN  PC of the Decode bundle (lane *i* PC = `PCD` + 4i).
- `Occupancy`  out  $clog2(DEPTH+1)  queued bundles, excluding the Decode register.

## Operation
- Storage is a circular FIFO of `DEPTH` entries plus one Decode register. Each entry holds {bundle, mask, PC}. Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. The count is tracked separately.
- Push condition: `BundleValidF & BundleReadyF & ~FlushD`.
- `BundleReadyF` = `(count < DEPTH) & reset`. It does not depend on `StallD`.
- Advance condition: `~StallD & ~FlushD`. When it holds, the Decode register loads from exactly one source, in this priority:
  1. FIFO head, if count > 0. This is a pop.
  2. Bypass: the pushed bundle, if count = 0 and a push occurs. The bundle goes straight to Decode and the count stays 0.
  3. Bubble otherwise.
- Push without bypass writes the tail. Simultaneous push and pop leaves the count unchanged.
- Slot expansion on load into Decode:
  - If mask bit *i* = 1: `InstrD_i` = bundle slot *i* and `InstrValidD_i` = 1.
  - If mask bit *i* = 0: `InstrD_i` = 32'h00000013 (addi x0,x0,0) and `InstrValidD_i` = 0.
- Bubble: all four lanes get NOP with valid 0. `PCD` holds its previous value.
- `FlushD`, regardless of `StallD`:
  - Next cycle the Decode register is a bubble.
  - Count = 0 and both pointers reset to 0.
  - A same-cycle push is dropped, even though `BundleReadyF` may be 1.
- `StallD` without flush: the Decode register holds, and pushes still enter the FIFO while count < `DEPTH`.
- Reset (`reset`=0, sampled on a clock edge):
  - Count and pointers = 0.
  - Decode register = bubble: `InstrD_*` = 32'h00000013, `InstrValidD_*` = 0, `PCD` = 0.
  - `Occupancy` = 0 and `BundleReadyF` = 0.
  - Reset mid-operation drops all contents.
- FIFO data arrays are not reset and are only read when count > 0.

## Timing
- All outputs are registered except `BundleReadyF`, which is a combinational decode of count and reset.
- Latency when empty and unstalled: a bundle accepted at edge N appears on `InstrD_*` after edge N (bypass, 1 cycle).
- Latency when queued: an entry at the head appears in Decode one edge after the first cycle in which the advance condition holds.
- Full (count = `DEPTH`): `BundleReadyF` = 0. It returns to 1 the cycle after a pop or flush.
- Throughput: 1 bundle per cycle sustained when `StallD` = 0.
- FIFO order is strict. No reordering and no partial-bundle issue.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles, then release. Required: all `InstrD_*` = 32'h00000013, all valids 0, `PCD` = 0, `Occupancy` = 0, `BundleReadyF` = 0 during reset and 1 after.
- **Bypass latency:** queue empty, `StallD`=0. Push bundle {0x00500093, 0x00A00113, 0x00208193, 0x00000000}, mask 4'b0111, PC 0x80000000. Required, next cycle:
  - `InstrD_0` = 0x00500093, `InstrD_1` = 0x00A00113, `InstrD_2` = 0x00208193.
  - `InstrD_3` = 0x00000013 with `InstrValidD_3` = 0.
  - `PCD` = 0x80000000, `Occupancy` = 0.
- **Fill/full:** `StallD`=1. Push PCs 0x100, 0x110, 0x120, 0x130. Required: `Occupancy` reaches 4 and `BundleReadyF` = 0; a 5th push is not accepted. Then release `StallD`: Decode shows PCs 0x100, 0x110, 0x120, 0x130 on consecutive cycles, and `BundleReadyF` returns to 1 one cycle after the first pop.
- **Wrap and concurrency:** at count 2, push and pop every cycle for 10 cycles. Required: `Occupancy` stays 2 throughout, and the PC sequence is in order across the pointer wrap.
- **Flush:** count 3, `StallD`=1, `FlushD`=1 together with a push. Required, next cycle: `Occupancy` = 0, all valids 0, and the pushed bundle never appears. The following push is bypassed normally.
- **Reset mid-operation:** count 3, Decode valid, assert `reset`=0 for one edge. Required: identical to the post-reset state, and no stale bundle appears on a later pop.
